tl_interval_timer: RTL and testbench

Parametrised multi-channel interval timer for the traffic-light controller, replacing the fixed one-second/five-second timer. A shared prescaler divides `clk` into a periodic `tick` strobe. NUM_CH independent down-counting channels each count a loadable number of ticks and pulse an expiry flag. Each channel runs one-shot or periodic and can be stopped or reloaded at any time. Typical use: one channel per phase duration (green, amber, all-red, pedestrian), all counting in seconds.

---
 rtl/tl_interval_timer.sv | 129 ++++++++++++
 tb/tb_tl_interval_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_interval_timer.sv
// Multi-channel interval timer: shared prescaler producing a periodic tick strobe
// plus NUM_CH independent one-shot/periodic down-counters with expiry pulses.
//
// state | meaning
// IDLE  | channel stopped, remain held at 0
// RUN   | channel counting ticks down towards expiry
module tl_interval_timer #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      tick_en,
   input  logic                      sync_clear,
   input  logic [NUM_CH-1:0]         ch_load,
   input  logic [NUM_CH*CNT_W-1:0]   ch_load_val,
   input  logic [NUM_CH-1:0]         ch_mode,
   input  logic [NUM_CH-1:0]         ch_stop,
   output logic                      tick,
   output logic [NUM_CH-1:0]         ch_expire,
   output logic [NUM_CH-1:0]         ch_busy,
   output logic [NUM_CH*CNT_W-1:0]   ch_remain
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    DIV_M1 = PW'(DIV - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   if (DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_div
      $error("tl_interval_timer: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
   end

   if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("tl_interval_timer: NUM_CH must be in 1..16");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (sync_clear) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (tick_en) begin
         if (pre_cnt == DIV_M1) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
            tick    <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t        state;
      logic [CNT_W-1:0] remain;
      logic [CNT_W-1:0] period;
      logic             mode;
      logic             expire;
      logic             busy;
      logic [CNT_W-1:0] load_val;

      assign load_val = ch_load_val[i*CNT_W +: CNT_W];

      // Priority is load > stop > tick, so a tick coinciding with a load is dropped.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state  <= IDLE;
            remain <= '0;
            period <= '0;
            mode   <= 1'b0;
            expire <= 1'b0;
            busy   <= 1'b0;
         end else begin
            expire <= 1'b0;
            if (ch_load[i]) begin
               if (load_val != '0) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  remain <= load_val;
                  period <= load_val;
                  mode   <= ch_mode[i];
               end else begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  remain <= '0;
               end
            end else if (ch_stop[i]) begin
               if (state == RUN) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  remain <= '0;
               end
            end else if (state == RUN && tick) begin
               if (remain > ONE) begin
                  remain <= remain - ONE;
               end else begin
                  expire <= 1'b1;
                  if (mode) begin
                     remain <= period;
                  end else begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     remain <= '0;
                  end
               end
            end
         end
      end

      assign ch_expire[i]                 = expire;
      assign ch_busy[i]                   = busy;
      assign ch_remain[i*CNT_W +: CNT_W]  = remain;
   end

endmodule

// File: tb/tb_tl_interval_timer.sv
// Directed bench for tl_interval_timer with DIV=10; positions are counted in
// clock edges after the edge that samples the load/sync_clear (E0).
module tb_tl_interval_timer;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic                    clk;
   logic                    reset_n;
   logic                    tick_en;
   logic                    sync_clear;
   logic [NUM_CH-1:0]       ch_load;
   logic [NUM_CH*CNT_W-1:0] ch_load_val;
   logic [NUM_CH-1:0]       ch_mode;
   logic [NUM_CH-1:0]       ch_stop;
   logic                    tick;
   logic [NUM_CH-1:0]       ch_expire;
   logic [NUM_CH-1:0]       ch_busy;
   logic [NUM_CH*CNT_W-1:0] ch_remain;

   int tests_run = 0;
   int tests_failed = 0;

   tl_interval_timer #(
      .CLK_FREQ_HZ (10),
      .TICK_HZ     (1),
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick_en     (tick_en),
      .sync_clear  (sync_clear),
      .ch_load     (ch_load),
      .ch_load_val (ch_load_val),
      .ch_mode     (ch_mode),
      .ch_stop     (ch_stop),
      .tick        (tick),
      .ch_expire   (ch_expire),
      .ch_busy     (ch_busy),
      .ch_remain   (ch_remain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic go(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] rem(input int ch);
      return ch_remain[ch*CNT_W +: CNT_W];
   endfunction

   task automatic set_val(input int ch, input int v);
      ch_load_val[ch*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   logic seen;

   initial begin
      reset_n     = 1'b0;
      tick_en     = 1'b0;
      sync_clear  = 1'b0;
      ch_load     = '0;
      ch_load_val = '0;
      ch_mode     = '0;
      ch_stop     = '0;
      #12;
      chk("rst_tick",   32'(tick),      32'h0);
      chk("rst_expire", 32'(ch_expire), 32'h0);
      chk("rst_busy",   32'(ch_busy),   32'h0);
      chk("rst_remain", ch_remain,      32'h0);
      go(2);
      reset_n = 1'b1;
      go(2);

      // Prescaler period and pause
      tick_en = 1'b1; sync_clear = 1'b1;
      go(1);
      sync_clear = 1'b0;
      go(9);  chk("pre_e9",  32'(tick), 32'h0);
      go(1);  chk("pre_e10", 32'(tick), 32'h1);
      go(1);  chk("pre_e11", 32'(tick), 32'h0);
      go(9);  chk("pre_e20", 32'(tick), 32'h1);
      tick_en = 1'b0;
      go(5);  chk("pause_e25", 32'(tick), 32'h0);
      tick_en = 1'b1;
      go(5);  chk("pause_e30", 32'(tick), 32'h0);
      go(4);  chk("pause_e34", 32'(tick), 32'h0);
      go(1);  chk("pause_e35", 32'(tick), 32'h1);

      // One-shot, V=3 on channel 0 (load coincides with a pending tick)
      sync_clear = 1'b1; ch_load = 4'b0001; set_val(0, 3); ch_mode = 4'b0000;
      go(1);
      sync_clear = 1'b0; ch_load = '0;
      chk("os_rem_e0",  32'(rem(0)), 32'd3);
      chk("os_busy_e0", 32'(ch_busy[0]), 32'h1);
      go(11); chk("os_rem_e11", 32'(rem(0)), 32'd2);
      go(10); chk("os_rem_e21", 32'(rem(0)), 32'd1);
      go(9);  chk("os_exp_e30", 32'(ch_expire), 32'h0);
      go(1);
      chk("os_exp_e31",  32'(ch_expire), 32'h1);
      chk("os_busy_e31", 32'(ch_busy[0]), 32'h0);
      chk("os_rem_e31",  32'(rem(0)), 32'd0);
      go(1);  chk("os_exp_e32", 32'(ch_expire), 32'h0);

      // Periodic, V=2 on channel 1, stopped at E50
      sync_clear = 1'b1; ch_load = 4'b0010; set_val(1, 2); ch_mode = 4'b0010;
      go(1);
      sync_clear = 1'b0; ch_load = '0; ch_mode = '0;
      go(20); chk("per_exp_e20", 32'(ch_expire), 32'h0);
      go(1);
      chk("per_exp_e21", 32'(ch_expire), 32'h2);
      chk("per_rem_e21", 32'(rem(1)), 32'd2);
      chk("per_busy_e21", 32'(ch_busy[1]), 32'h1);
      go(1);  chk("per_exp_e22", 32'(ch_expire), 32'h0);
      go(19); chk("per_exp_e41", 32'(ch_expire), 32'h2);
      go(8);
      ch_stop = 4'b0010;
      go(1);
      ch_stop = '0;
      chk("per_rem_e50", 32'(rem(1)), 32'd0);
      go(1);  chk("per_busy_e51", 32'(ch_busy[1]), 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         go(1);
         seen |= ch_expire[1];
      end
      chk("per_no_exp_after_stop", 32'(seen), 32'h0);

      // Reload on the final tick, then stop on the final tick (channel 2)
      sync_clear = 1'b1; ch_load = 4'b0100; set_val(2, 2);
      go(1);
      sync_clear = 1'b0; ch_load = '0;
      go(11); chk("pri_rem_e11", 32'(rem(2)), 32'd1);
      go(9);
      ch_load = 4'b0100; set_val(2, 5);
      go(1);
      ch_load = '0;
      chk("pri_reload_exp", 32'(ch_expire), 32'h0);
      chk("pri_reload_rem", 32'(rem(2)), 32'd5);
      go(40); chk("pri_rem_e61", 32'(rem(2)), 32'd1);
      go(9);
      ch_stop = 4'b0100;
      go(1);
      ch_stop = '0;
      chk("pri_stop_exp",  32'(ch_expire), 32'h0);
      chk("pri_stop_busy", 32'(ch_busy[2]), 32'h0);
      go(1);  chk("pri_stop_exp_next", 32'(ch_expire), 32'h0);

      // V=0 load keeps the channel idle
      ch_load = 4'b1000; set_val(3, 0);
      go(1);
      ch_load = '0;
      chk("v0_busy", 32'(ch_busy[3]), 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         go(1);
         seen |= ch_expire[3];
      end
      chk("v0_no_exp", 32'(seen), 32'h0);

      // V=255 on channel 0, two simultaneous V=4 channels
      sync_clear = 1'b1; ch_load = 4'b0111; ch_mode = '0;
      set_val(0, 255); set_val(1, 4); set_val(2, 4);
      go(1);
      sync_clear = 1'b0; ch_load = '0;
      chk("max_rem_e0", 32'(rem(0)), 32'd255);
      go(40);   chk("sim_exp_e40", 32'(ch_expire), 32'h0);
      go(1);    chk("sim_exp_e41", 32'(ch_expire), 32'h6);
      go(2509);
      chk("max_exp_e2550", 32'(ch_expire), 32'h0);
      chk("max_rem_e2550", 32'(rem(0)), 32'd1);
      go(1);
      chk("max_exp_e2551",  32'(ch_expire), 32'h1);
      chk("max_busy_e2551", 32'(ch_busy), 32'h0);

      // Asynchronous reset mid-count
      sync_clear = 1'b1; ch_load = 4'b0011; ch_mode = 4'b0001;
      set_val(0, 3); set_val(1, 3);
      go(1);
      sync_clear = 1'b0; ch_load = '0; ch_mode = '0;
      go(25);
      chk("rst_pre_rem", 32'(rem(0)), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy",   32'(ch_busy),   32'h0);
      chk("arst_remain", ch_remain,      32'h0);
      chk("arst_expire", 32'(ch_expire), 32'h0);
      chk("arst_tick",   32'(tick),      32'h0);
      go(3);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         go(1);
         seen |= |ch_expire;
      end
      chk("arst_no_stale_exp", 32'(seen), 32'h0);
      chk("arst_busy_after",   32'(ch_busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
